// File: rtl/matrix_loader.sv
// matrix_loader
//   Receives a 4-word dimension header (r1, c1, r2, c2) followed by the
//   row-major elements of matrix A (r1 x c1) and then matrix B (r2 x c2).
//   Both matrices are stored in on-chip buffers and exposed through a
//   registered random-access read port once the load is complete.
//
// Ports
//   CLK, RST            clock, synchronous active-high reset
//   in_valid/in_ready   input word handshake
//   in_hdr, in_data     word kind (1 = header) and payload
//   r1, c1, r2, c2      latched dimensions of A and B
//   load_done, err      load complete / protocol or dimension error
//   release_req         one-cycle pulse returning DONE or ERR to IDLE
//                       ("release" itself is a reserved word)
//   rd_en, rd_sel       read request, 0 = A, 1 = B
//   rd_row, rd_col      element index
//   rd_valid, rd_data   read response, one cycle after rd_en
module matrix_loader #(
  parameter int DATA_W  = 32,
  parameter int MAX_DIM = 4,
  parameter int DIM_W   = 4
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_hdr,
  input  logic [DATA_W-1:0] in_data,
  output logic [DIM_W-1:0]  r1,
  output logic [DIM_W-1:0]  c1,
  output logic [DIM_W-1:0]  r2,
  output logic [DIM_W-1:0]  c2,
  output logic              load_done,
  output logic              err,
  input  logic              release_req,
  input  logic              rd_en,
  input  logic              rd_sel,
  input  logic [DIM_W-1:0]  rd_row,
  input  logic [DIM_W-1:0]  rd_col,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data
);

  localparam int IDX_W = (MAX_DIM > 1) ? $clog2(MAX_DIM) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_LOAD_A, S_LOAD_B, S_DONE, S_ERR
  } state_t;

  state_t             state;
  logic [1:0]         hdr_cnt;
  logic [DIM_W-1:0]   row;
  logic [DIM_W-1:0]   col;

  logic [DATA_W-1:0]  mem_a [MAX_DIM][MAX_DIM];
  logic [DATA_W-1:0]  mem_b [MAX_DIM][MAX_DIM];

  logic               accept;
  logic [DIM_W-1:0]   hdr_dim;
  logic               hdr_valid;
  logic               fault;
  logic [DIM_W-1:0]   sel_rows;
  logic [DIM_W-1:0]   sel_cols;
  logic               rd_in_range;
  logic [DATA_W-1:0]  rd_word;

  function automatic logic dim_ok(input logic [DIM_W-1:0] d);
    return (d != '0) && (d <= DIM_W'(MAX_DIM));
  endfunction

  assign accept  = in_valid && in_ready;
  assign hdr_dim = in_data[DIM_W-1:0];

  // c2 is still on the input bus when the header is validated.
  assign hdr_valid = dim_ok(r1) && dim_ok(c1) && dim_ok(r2) && dim_ok(hdr_dim)
                     && (c1 == r2);

  // An accepted word that breaks the header/element ordering, or a header
  // that fails validation, sends the loader to ERR.
  always_comb begin
    // NOTE: default first so every path assigns fault and no latch is inferred.
    fault = 1'b0;
    if (accept) begin
      case (state)
        S_IDLE:             fault = !in_hdr;
        S_HDR:              fault = !in_hdr || ((hdr_cnt == 2'd3) && !hdr_valid);
        S_LOAD_A, S_LOAD_B: fault = in_hdr;
        default:            fault = 1'b0;
      endcase
    end
  end

  // The range check masks any index beyond the selected matrix, so the
  // truncated buffer index below never exposes an unwritten cell.
  assign sel_rows    = rd_sel ? r2 : r1;
  assign sel_cols    = rd_sel ? c2 : c1;
  assign rd_in_range = (rd_row < sel_rows) && (rd_col < sel_cols);
  assign rd_word     = rd_sel ? mem_b[rd_row[IDX_W-1:0]][rd_col[IDX_W-1:0]]
                              : mem_a[rd_row[IDX_W-1:0]][rd_col[IDX_W-1:0]];

  // NOTE: buffer contents are deliberately not reset; the range check keeps
  // stale cells unreadable, and leaving reset off lets them map to RAM.
  always_ff @(posedge CLK) begin
    if (accept && !in_hdr && state == S_LOAD_A)
      mem_a[row[IDX_W-1:0]][col[IDX_W-1:0]] <= in_data;
    if (accept && !in_hdr && state == S_LOAD_B)
      mem_b[row[IDX_W-1:0]][col[IDX_W-1:0]] <= in_data;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      // NOTE: state is assigned with <= so every register samples pre-edge values.
      state     <= S_IDLE;
      in_ready  <= 1'b1;
      load_done <= 1'b0;
      err       <= 1'b0;
      r1        <= '0;
      c1        <= '0;
      r2        <= '0;
      c2        <= '0;
      hdr_cnt   <= '0;
      row       <= '0;
      col       <= '0;
      rd_valid  <= 1'b0;
      rd_data   <= '0;
    end else begin
      // Read port: serviced only in DONE; rd_data otherwise holds unless a
      // read is requested outside DONE, which returns zero.
      rd_valid <= (state == S_DONE) && rd_en;
      if (rd_en)
        rd_data <= ((state == S_DONE) && rd_in_range) ? rd_word : '0;

      case (state)
        S_IDLE: begin
          if (accept && in_hdr) begin
            r1      <= hdr_dim;
            hdr_cnt <= 2'd1;
            state   <= S_HDR;
          end
        end
        S_HDR: begin
          if (accept && in_hdr) begin
            case (hdr_cnt)
              2'd1: begin c1 <= hdr_dim; hdr_cnt <= 2'd2; end
              2'd2: begin r2 <= hdr_dim; hdr_cnt <= 2'd3; end
              default: begin
                c2      <= hdr_dim;
                hdr_cnt <= '0;
                row     <= '0;
                col     <= '0;
                state   <= S_LOAD_A;
              end
            endcase
          end
        end
        S_LOAD_A: begin
          if (accept && !in_hdr) begin
            if (col == c1 - DIM_W'(1)) begin
              col <= '0;
              if (row == r1 - DIM_W'(1)) begin
                row   <= '0;
                state <= S_LOAD_B;
              end else begin
                row <= row + DIM_W'(1);
              end
            end else begin
              col <= col + DIM_W'(1);
            end
          end
        end
        S_LOAD_B: begin
          if (accept && !in_hdr) begin
            if (col == c2 - DIM_W'(1)) begin
              col <= '0;
              if (row == r2 - DIM_W'(1)) begin
                row       <= '0;
                state     <= S_DONE;
                load_done <= 1'b1;
                in_ready  <= 1'b0;
              end else begin
                row <= row + DIM_W'(1);
              end
            end else begin
              col <= col + DIM_W'(1);
            end
          end
        end
        S_DONE: begin
          if (release_req) begin
            state     <= S_IDLE;
            load_done <= 1'b0;
            in_ready  <= 1'b1;
            r1        <= '0;
            c1        <= '0;
            r2        <= '0;
            c2        <= '0;
          end
        end
        S_ERR: begin
          if (release_req) begin
            state    <= S_IDLE;
            err      <= 1'b0;
            in_ready <= 1'b1;
          end
        end
        default: begin
          state    <= S_IDLE;
          in_ready <= 1'b1;
        end
      endcase

      // Overrides any transition above; latched dimensions are kept.
      if (fault) begin
        state    <= S_ERR;
        err      <= 1'b1;
        in_ready <= 1'b0;
        hdr_cnt  <= '0;
        row      <= '0;
        col      <= '0;
      end
    end
  end

endmodule
